// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin arbiter sharing one data_bus between two masters.
// Master 0 is the CPU, master 1 a secondary requester (DMA/debug).
// Optional feature macro: ARB_RANGE_CHECK_EN. When it is defined, winners whose
// address lies above MEM_END are answered with an error and never reach the bus.
// MEM_END comes from memory_map.v when that is compiled ahead of this file.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no access in flight; arbitrate on m0_req/m1_req
// ACCESS | bus_en high, request fields held; counts down BUS_LAT cycles
// RESP   | one-cycle ack to the winner; update last_grant
`ifndef MEM_END
`define MEM_END 64'h0000_0000_FFFF_FFFF
`endif

module data_bus_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int BUS_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_rw,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_rw,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          bus_en,
  output logic          bus_rw,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_write,
  input  logic [DW-1:0] bus_read,
  input  logic          bus_exception
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          winner_q, winner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          err0_q, err0_d, err1_q, err1_d;

  logic          sel;
  logic          sel_rw;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // On a tie the master that did not win last time gets the bus; last_grant
  // resets to 1 so master 0 goes first.
  assign sel       = (m0_req && m1_req) ? ~last_grant_q : m1_req;
  assign sel_rw    = sel ? m1_rw    : m0_rw;
  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;

  // Next-state and datapath logic for the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          winner_d = sel;
`ifdef ARB_RANGE_CHECK_EN
          if (sel_addr > `MEM_END) begin
            state_d = S_RESP;
            if (sel) begin
              rdata1_d = '0;
              err1_d   = 1'b1;
            end else begin
              rdata0_d = '0;
              err0_d   = 1'b1;
            end
          end else begin
`else
          begin
`endif
            addr_d  = sel_addr;
            rw_d    = sel_rw;
            wdata_d = sel_wdata;
            cnt_d   = 4'(BUS_LAT);
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (winner_q) begin
            rdata1_d = bus_read;
            err1_d   = bus_exception;
          end else begin
            rdata0_d = bus_read;
            err0_d   = bus_exception;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        last_grant_d = winner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  // bus_rw is gated with bus_en so a stale write flag never reaches the bus.
  assign bus_en    = (state_q == S_ACCESS);
  assign bus_rw    = bus_en && rw_q;
  assign bus_addr  = addr_q;
  assign bus_write = wdata_q;

  assign m0_ack    = (state_q == S_RESP) && !winner_q;
  assign m1_ack    = (state_q == S_RESP) &&  winner_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign m0_err    = err0_q;
  assign m1_err    = err1_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with BUS_LAT=1: table-driven single
// transactions plus hand-written reset and round-robin sequences.
module tb_data_bus_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_rw, m1_req, m1_rw;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          bus_en, bus_rw;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_write, bus_read;
  logic          bus_exception;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_rdata [2];
  logic          exp_err   [2];

  typedef struct {
    logic          m0_req;
    logic          m0_rw;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m1_req;
    logic          m1_rw;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [DW-1:0] rd;
    logic          exc;
    logic          exp_win;
    logic          exp_rw;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wr;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vt [6];

  data_bus_arbiter #(.AW(AW), .DW(DW), .BUS_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .bus_en(bus_en), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_read(bus_read), .bus_exception(bus_exception)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " outputs"},
        64'({m0_ack, m0_err, m1_ack, m1_err, bus_en, bus_rw}), 64'd0);
    chk({tag, " m0_rdata"}, m0_rdata, 64'd0);
    chk({tag, " m1_rdata"}, m1_rdata, 64'd0);
    chk({tag, " bus_addr"}, bus_addr, 64'd0);
    chk({tag, " bus_write"}, bus_write, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_rw = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_rw = 0; m1_addr = '0; m1_wdata = '0;
    bus_read = '0; bus_exception = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;

    //        m0 req rw addr    wdata   m1 req rw addr    wdata   bus_read              exc win rw addr    wr      rdata                 err
    vt[0] = '{1, 0, 64'h10, 64'h0,  0, 0, 64'h0,  64'h0,  64'h00000000DEADBEEF, 0,  0,  0, 64'h10, 64'h0,  64'h00000000DEADBEEF, 0};
    vt[1] = '{0, 0, 64'h0,  64'h0,  1, 1, 64'h20, 64'h55, 64'h1234,             0,  1,  1, 64'h20, 64'h55, 64'h1234,             0};
    vt[2] = '{1, 0, 64'h8,  64'h0,  0, 0, 64'h0,  64'h0,  64'hCAFE,             1,  0,  0, 64'h8,  64'h0,  64'hCAFE,             1};
    vt[3] = '{1, 1, 64'h18, 64'hAA, 0, 0, 64'h0,  64'h0,  64'h0,                0,  0,  1, 64'h18, 64'hAA, 64'h0,                0};
    // tie with last_grant=0 -> m1 wins
    vt[4] = '{1, 0, 64'h40, 64'h0,  1, 0, 64'h30, 64'h0,  64'h777,              0,  1,  0, 64'h30, 64'h0,  64'h777,              0};
    // tie with last_grant=1 -> m0 wins
    vt[5] = '{1, 1, 64'h50, 64'h99, 1, 0, 64'h60, 64'h0,  64'h4242,             1,  0,  1, 64'h50, 64'h99, 64'h4242,             1};

    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Table-driven single transactions; cycle 0 is the IDLE cycle holding req.
    for (int i = 0; i < 6; i++) begin
      m0_req = vt[i].m0_req; m0_rw = vt[i].m0_rw; m0_addr = vt[i].m0_addr; m0_wdata = vt[i].m0_wdata;
      m1_req = vt[i].m1_req; m1_rw = vt[i].m1_rw; m1_addr = vt[i].m1_addr; m1_wdata = vt[i].m1_wdata;
      bus_read = vt[i].rd; bus_exception = vt[i].exc;
      for (int c = 1; c <= 2; c++) begin
        tick();
        chk($sformatf("v%0d c%0d bus_en", i, c), 64'(bus_en), 64'd1);
        chk($sformatf("v%0d c%0d bus_rw", i, c), 64'(bus_rw), 64'(vt[i].exp_rw));
        chk($sformatf("v%0d c%0d bus_addr", i, c), bus_addr, vt[i].exp_addr);
        chk($sformatf("v%0d c%0d bus_write", i, c), bus_write, vt[i].exp_wr);
        chk($sformatf("v%0d c%0d acks", i, c), 64'({m0_ack, m1_ack}), 64'd0);
      end
      tick();
      exp_rdata[vt[i].exp_win] = vt[i].exp_rdata;
      exp_err[vt[i].exp_win]   = vt[i].exp_err;
      chk($sformatf("v%0d ack", i), 64'({m1_ack, m0_ack}), vt[i].exp_win ? 64'd2 : 64'd1);
      chk($sformatf("v%0d resp bus_en/rw", i), 64'({bus_en, bus_rw}), 64'd0);
      chk($sformatf("v%0d m0_rdata", i), m0_rdata, exp_rdata[0]);
      chk($sformatf("v%0d m1_rdata", i), m1_rdata, exp_rdata[1]);
      chk($sformatf("v%0d m0_err", i), 64'(m0_err), 64'(exp_err[0]));
      chk($sformatf("v%0d m1_err", i), 64'(m1_err), 64'(exp_err[1]));
      m0_req = 0; m1_req = 0; bus_exception = 0;
      tick();
      chk($sformatf("v%0d idle", i), 64'({bus_en, bus_rw, m0_ack, m1_ack}), 64'd0);
    end

    // Tie after reset with both requests held: m0, m1, m0, m1 at cycles 3,7,11,15.
    do_reset();
    m0_req = 1; m0_rw = 0; m0_addr = 64'h100;
    m1_req = 1; m1_rw = 0; m1_addr = 64'h200;
    bus_read = 64'h5A5A; bus_exception = 0;
    for (int c = 1; c <= 16; c++) begin
      logic [1:0] exp_acks;
      tick();
      exp_acks = (c == 3 || c == 11) ? 2'b01 : (c == 7 || c == 15) ? 2'b10 : 2'b00;
      chk($sformatf("rr c%0d acks", c), 64'({m1_ack, m0_ack}), 64'(exp_acks));
      if (c == 5)
        chk("rr c5 bus_addr", bus_addr, 64'h200);
      if (c == 9)
        chk("rr c9 bus_addr", bus_addr, 64'h100);
    end
    m0_req = 0; m1_req = 0;
    tick();

    // Reset in the second ACCESS cycle: outputs clear at once, no stale ack.
    do_reset();
    tick();
    m0_req = 1; m0_rw = 1; m0_addr = 64'h10; m0_wdata = 64'h77;
    bus_read = 64'hBEEF;
    tick();
    tick();
    chk("midop before reset bus_en", 64'(bus_en), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midop reset");
    m0_req = 0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("post-reset c%0d quiet", c), 64'({m0_ack, m1_ack, bus_en}), 64'd0);
    end
    m1_req = 1; m1_rw = 0; m1_addr = 64'h28; bus_read = 64'h3C3C;
    tick();
    chk("fresh bus_addr", bus_addr, 64'h28);
    tick();
    chk("fresh c2 acks", 64'({m0_ack, m1_ack}), 64'd0);
    tick();
    chk("fresh ack", 64'({m1_ack, m0_ack}), 64'd2);
    chk("fresh m1_rdata", m1_rdata, 64'h3C3C);
    chk("fresh m0_rdata", m0_rdata, 64'd0);
    m1_req = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
Two-master arbiter that shares the single `data_bus` port between the `zipocpu` (master 0) and a secondary requester such as a DMA or debug unit (master 1).
- Serialises requests with round-robin fairness.
- Drives the bus address/control/write lines for a fixed access window.
- Samples `read` data and `exception`, then returns them to the winner with a one-cycle ack pulse.

Parameters:
- AW, 64: address width.
- DW, 64: data width.
- BUS_LAT, 1: extra cycles the bus needs after address presentation before read/exception are valid. Legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 request; held until ack.
- m0_rw  in  1  1 = write, 0 = read.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_rdata  out  DW  read data, valid with m0_ack.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  bus exception, valid with m0_ack.
- m1_req, m1_rw, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: same as master 0.
- bus_en  out  1  access strobe to data_bus.
- bus_rw  out  1  to data_bus rw.
- bus_addr  out  AW  to data_bus addr.
- bus_write  out  DW  to data_bus write.
- bus_read  in  DW  from data_bus read.
- bus_exception  in  1  from data_bus exception.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, last_grant=1, counter=0.
  - All outputs 0.
  - Any in-flight access is abandoned with no ack.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, choose a winner. A single requester wins. On a tie, the master != last_grant wins.
  - Latch winner's addr/rw/wdata into bus_addr/bus_rw/bus_write; cnt <= BUS_LAT; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - bus_en=1; bus_addr/bus_rw/bus_write held constant.
  - If cnt==0: capture bus_read into the winner's rdata register and bus_exception into its err; go to RESP.
  - Else cnt <= cnt-1.
  - ACCESS lasts exactly BUS_LAT+1 cycles.
- RESP:
  - Winner's ack=1 for one cycle; last_grant <= winner; go to IDLE.
  - bus_en=0, bus_rw=0.
- Outside ACCESS: bus_en=0 and bus_rw=0, so no spurious writes. bus_addr/bus_write keep their last values.
- Latency: a request sampled in IDLE at cycle 0 gets its ack at cycle BUS_LAT+2. Minimum turnaround between two grants is BUS_LAT+3 cycles.
- Requester rules:
  - Hold req/addr/rw/wdata stable until ack.
  - Deassert req on the edge where ack is sampled, or keep it high to issue a new request.
  - Changes to request fields while a transaction is granted are ignored, because the fields are latched.
- rdata/err: hold until the next ack to the same master. The non-winner's ack stays 0.
- Writes: rdata is still updated with the sampled bus_read; err is valid for both reads and writes.
- Round-robin starvation bound: with both masters continuously requesting, grants alternate strictly, m0 first after reset.
- A request arriving during ACCESS/RESP is only evaluated in the next IDLE.

Optional Feature:
- Macro: ARB_RANGE_CHECK_EN.
- When defined, in IDLE the winner's addr is compared against `MEM_END (from memory_map.v).
  - addr > `MEM_END: skip ACCESS and go directly to RESP. ack is at cycle 1 with err=1 and rdata=0. bus_en never asserts. last_grant updates normally.
  - addr <= `MEM_END: normal flow.
- When undefined, all addresses are forwarded to the bus and errors come only from bus_exception.

Test Plan:
- Reset mid-op: assert rst_n=0 in the second ACCESS cycle -> all outputs 0 immediately; after release, the next request is treated fresh with no stale ack.
- Single read: BUS_LAT=1; m0 reads addr 0x10 with bus_read=0x00000000DEADBEEF, exception=0 -> bus_en high cycles 1-2, bus_rw=0, m0_ack at cycle 3 only, m0_rdata=0xDEADBEEF, m0_err=0.
- Single write: m1 writes addr 0x20, data 0x55 -> bus_rw=1, bus_addr=0x20, bus_write=0x55 for 2 cycles; m1_ack at cycle 3; m0_ack stays 0.
- Tie after reset: m0 and m1 request together and hold -> grants m0, m1, m0, m1; acks at cycles 3, 7, 11, 15.
- Exception: m0 read addr 0x8 with bus_exception=1 at sample cycle -> m0_ack=1, m0_err=1; the next clean access clears err.
- With ARB_RANGE_CHECK_EN: m0 read at `MEM_END+1 -> m0_ack at cycle 1, m0_err=1, m0_rdata=0, bus_en never high.
